snes_input_events: RTL
======================

// Module: snes_input_events
// PURPOSE
//   Downstream of the SNES controller serial reader. Takes each decoded 16-bit
//   button sample, detects per-button press/release transitions against the
//   previous sample, and queues one 8-bit event per transition in a small FIFO.
//   The processor reads events through a pop port; irq flags pending events.
// PARAMETERS
//   DEPTH  8  event FIFO entries; power of two, >= 2
// PORTS
//   clk         in   1   system clock, all logic rising-edge
//   rst         in   1   asynchronous, active-high reset
//   btn_word    in   16  decoded sample, 1 = pressed, bit i = i-th bit shifted out
//   btn_valid   in   1   one-cycle strobe: btn_word holds a new complete sample
//   rd_en       in   1   pop head event (ignored when evt_empty=1)
//   irq_en      in   1   interrupt enable
//   ovf_clr     in   1   clear the sticky overflow and drop flags
//   evt_data    out  8   head event, show-ahead: {press, 3'b000, idx[3:0]}
//   evt_empty   out  1   FIFO empty
//   evt_count   out  $clog2(DEPTH+1)  entries held, 0..DEPTH
//   cur_buttons out  16  last captured sample
//   overflow    out  1   sticky: an event was lost because the FIFO was full
//   sample_drop out  1   sticky: btn_valid arrived while SCAN was busy
//   irq         out  1   level: irq_en & ~evt_empty
// BEHAVIOUR
//   Reset: prev/cur_buttons=0, FIFO empty, evt_count=0, evt_data=0,
//     overflow=0, sample_drop=0, FSM=IDLE. Reset mid-SCAN discards the scan.
//     Buttons already held at reset produce press events on the first sample.
//   FSM IDLE: on btn_valid, diff=btn_word^prev; prev,cur_buttons,snap<=btn_word;
//     diff!=0 -> SCAN with mask<=diff; diff==0 -> stay IDLE, no event.
//   FSM SCAN: each cycle take lowest set bit i of mask, push {snap[i],3'b0,i},
//     clear mask[i]; the push clearing the last set bit returns FSM to IDLE.
//     One event per cycle, ascending bit index order.
//   btn_valid while in SCAN: sample ignored (prev unchanged), sample_drop<=1.
//   Latency: btn_valid at edge N -> first event visible (evt_empty=0) after
//     edge N+1; k changed bits -> last push at edge N+k.
//   FIFO: push when full -> event discarded, overflow<=1, scan continues.
//     Simultaneous push+pop when full: both succeed, count unchanged.
//     Simultaneous push+pop when empty: pop ignored, push succeeds.
//     Pointers wrap modulo DEPTH; count is exact 0..DEPTH.
//   ovf_clr clears both sticky flags; a same-cycle set wins over clear.
//   irq is combinational from registered state; no extra latency.
// STRUCTURE
//   snes_pkg: button index constants (B=0,Y=1,SELECT=2,START=3,UP=4,DOWN=5,
//     LEFT=6,RIGHT=7,A=8,X=9,L=10,R=11; bits 12-15 unused), event field
//     positions (EVT_PRESS_BIT=7, EVT_IDX_LSB=0, EVT_IDX_W=4), FSM state enum.
//   Sub-module: sync_fifo (WIDTH=8, DEPTH) - show-ahead, full/empty/count.
//   Top holds prev/snap/mask registers, priority encoder, FSM, sticky flags.
// TESTING
//   1. Reset, btn_word=16'h0001 + btn_valid -> one event 8'h80 after 1 cycle,
//      irq=1 with irq_en=1; pop -> evt_empty=1, irq=0.
//   2. From 16'h0001, sample 16'h0110 -> events 8'h00,8'h84,8'h88 in that
//      order on 3 consecutive cycles; cur_buttons=16'h0110.
//   3. Same sample twice -> no events on the second, FSM stays IDLE.
//   4. DEPTH=8, no pops, sample 16'h03FF from 0 -> 8 events held, count=8,
//      overflow=1, last 2 (idx 8,9) lost; ovf_clr -> overflow=0.
//   5. btn_valid during SCAN -> sample_drop=1, prev unchanged; next sample
//      diffs against the pre-drop value.
//   6. Full FIFO, push and rd_en same cycle -> count stays 8, head advances;
//      assert rst mid-SCAN -> all outputs at reset values, no further pushes.

Source files
------------

// File: rtl/snes_pkg.sv
// snes_pkg: button indices, event field layout and scan FSM states for the input event block
package snes_pkg;
  localparam int BTN_B = 0, BTN_Y = 1, BTN_SELECT = 2, BTN_START = 3;
  localparam int BTN_UP = 4, BTN_DOWN = 5, BTN_LEFT = 6, BTN_RIGHT = 7;
  localparam int BTN_A = 8, BTN_X = 9, BTN_L = 10, BTN_R = 11;
  localparam int EVT_PRESS_BIT = 7, EVT_IDX_LSB = 0, EVT_IDX_W = 4;
  typedef enum logic {ST_IDLE, ST_SCAN} state_t;
  function automatic logic [EVT_IDX_W-1:0] lowest_idx(input logic [15:0] m);
    lowest_idx = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) lowest_idx = EVT_IDX_W'(i);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with exact count; a full FIFO still accepts a push when popped the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_lost
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop, w_push;
  assign o_empty = r_count == '0;
  assign o_full = r_count == CW'(DEPTH);
  assign o_count = r_count;
  assign w_pop = i_rd_en & ~o_empty;
  assign w_push = i_wr_en & (~o_full | w_pop);
  assign o_lost = i_wr_en & o_full & ~w_pop;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= i_wr_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/snes_input_events.sv
// snes_input_events: turns button samples into per-button press/release events queued for the CPU
module snes_input_events
  import snes_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                btn_word,
  input  logic                       btn_valid,
  input  logic                       rd_en,
  input  logic                       irq_en,
  input  logic                       ovf_clr,
  output logic [7:0]                 evt_data,
  output logic                       evt_empty,
  output logic [$clog2(DEPTH+1)-1:0] evt_count,
  output logic [15:0]                cur_buttons,
  output logic                       overflow,
  output logic                       sample_drop,
  output logic                       irq
);
  state_t r_state, w_next;
  logic [15:0] r_prev, r_mask, w_mask_nxt;
  logic [EVT_IDX_W-1:0] w_idx;
  logic [7:0] w_evt;
  logic w_push, w_lost, w_full;
  assign w_idx = lowest_idx(r_mask);
  assign w_mask_nxt = r_mask & (r_mask - 16'd1);
  // r_prev is both the diff reference and the scan snapshot: it cannot change while scanning
  assign w_evt = {r_prev[w_idx], 3'b000, w_idx};
  assign w_push = r_state == ST_SCAN;
  assign cur_buttons = r_prev;
  assign irq = irq_en & ~evt_empty;
  always_comb w_next = r_state == ST_IDLE ? ((btn_valid && btn_word != r_prev) ? ST_SCAN : ST_IDLE)
                                           : (w_mask_nxt == '0 ? ST_IDLE : ST_SCAN);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_prev <= '0;
      r_mask <= '0;
      overflow <= 1'b0;
      sample_drop <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && btn_valid) begin
        r_prev <= btn_word;
        r_mask <= btn_word ^ r_prev;
      end else if (r_state == ST_SCAN) r_mask <= w_mask_nxt;
      overflow <= (overflow & ~ovf_clr) | w_lost;
      sample_drop <= (sample_drop & ~ovf_clr) | (btn_valid & (r_state == ST_SCAN));
    end
  end
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_wr_en(w_push), .i_wr_data(w_evt), .i_rd_en(rd_en),
    .o_rd_data(evt_data), .o_empty(evt_empty), .o_full(w_full), .o_count(evt_count), .o_lost(w_lost)
  );
endmodule
